mult_test_seq: RTL and testbench

MULT_TEST_SEQ -- requirements
Module: mult_test_seq

---
 rtl/mult_test_pkg.sv | 35 +++
 rtl/lfsr32_step.sv | 16 +
 rtl/mult_test_seq.sv | 107 ++++++++++
 tb/tb_mult_test_seq.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_test_pkg.sv
// Shared FSM state type, display status codes and LFSR taps for the multiplier self-test sequencer.
package mult_test_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone,
        StCheck,
        StNext,
        StPass,
        StFail,
        StError
    } state_t;

    localparam logic [4:0] STATUS_IDLE  = 5'h10;
    localparam logic [4:0] STATUS_RUN   = 5'h11;
    localparam logic [4:0] STATUS_PASS  = 5'h12;
    localparam logic [4:0] STATUS_FAIL  = 5'h13;
    localparam logic [4:0] STATUS_ERROR = 5'h14;

    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [4:0] status_of(state_t s);
        case (s)
            StIdle:  status_of = STATUS_IDLE;
            StPass:  status_of = STATUS_PASS;
            StFail:  status_of = STATUS_FAIL;
            StError: status_of = STATUS_ERROR;
            default: status_of = STATUS_RUN;
        endcase
    endfunction

endpackage

// File: rtl/lfsr32_step.sv
// One combinational Galois step of the 32-bit operand generator.
module lfsr32_step
    import mult_test_pkg::*;
(
    input  logic [31:0] state,
    output logic [31:0] next_state
);

    always_comb begin
        next_state = {1'b0, state[31:1]};
        if (state[0]) begin
            next_state = next_state ^ LFSR_POLY;
        end
    end

endmodule

// File: rtl/mult_test_seq.sv
// Self-test sequencer: feeds LFSR operand pairs to a multiplier under test and a gold model,
// waits for the busy handshake and checks the combinational match flag for each pair.
module mult_test_seq
    import mult_test_pkg::*;
#(
    parameter int unsigned NUM_TESTS      = 16,
    parameter logic [31:0] LFSR_SEED      = 32'h1234_5678,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        begin_test,
    input  logic        inject_error,
    input  logic        busy,
    input  logic        results_match,
    output logic [15:0] opA,
    output logic [15:0] opB,
    output logic        test_mult_start,
    output logic [4:0]  status_out,
    output logic [7:0]  test_index,
    output logic        done
);

    localparam int unsigned      CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       LAST_INDEX = 8'(NUM_TESTS - 1);

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_next;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             err_pending_q;
    logic             timeout_hit, mismatch, restart, waiting;

    lfsr32_step u_lfsr_step (
        .state      (lfsr_q),
        .next_state (lfsr_next)
    );

    // Operands come straight from the generator flops, so they only move on load or NEXT.
    assign opA = lfsr_q[31:16];
    assign opB = lfsr_q[15:0];

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_LAST);
    assign waiting     = (state_q == StWaitBusy) || (state_q == StWaitDone);
    // A pulse arriving in the CHECK cycle itself still counts against this check.
    assign mismatch    = ~results_match | err_pending_q | inject_error;
    assign restart     = begin_test && ((state_q == StIdle) || (state_q == StPass) ||
                                        (state_q == StFail) || (state_q == StError));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (begin_test) state_d = StStart;
            StStart:    state_d = StWaitBusy;
            StWaitBusy: begin
                if (busy)             state_d = StWaitDone;
                else if (timeout_hit) state_d = StError;
            end
            StWaitDone: begin
                if (!busy)            state_d = StCheck;
                else if (timeout_hit) state_d = StError;
            end
            StCheck: begin
                if (mismatch)                     state_d = StFail;
                else if (test_index == LAST_INDEX) state_d = StPass;
                else                               state_d = StNext;
            end
            StNext:                 state_d = StStart;
            StPass, StFail, StError: if (begin_test) state_d = StStart;
            default:                state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            lfsr_q          <= '0;
            cnt_q           <= '0;
            err_pending_q   <= 1'b0;
            test_index      <= '0;
            test_mult_start <= 1'b0;
            status_out      <= STATUS_IDLE;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            test_mult_start <= (state_d == StStart);
            status_out      <= status_of(state_d);
            done            <= (state_d == StPass) || (state_d == StFail) ||
                               (state_d == StError);
            err_pending_q   <= (state_q == StCheck) ? 1'b0 : (err_pending_q | inject_error);

            if (restart) begin
                lfsr_q     <= LFSR_SEED;
                test_index <= '0;
            end else if (state_q == StNext) begin
                lfsr_q     <= lfsr_next;
                test_index <= test_index + 8'd1;
            end

            // Cleared in START, then free-running across both wait states.
            if (waiting) cnt_q <= cnt_inc;
            else         cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_mult_test_seq.sv
// Randomised bench for mult_test_seq: multiplier busy model, gold-match model and per-cycle monitor.
module tb_mult_test_seq;

    localparam int unsigned N    = 16;
    localparam int unsigned T    = 64;
    localparam logic [31:0] SEED = 32'h1234_5678;

    logic        clock = 1'b0;
    logic        reset_n, begin_test, inject_error, busy, results_match;
    logic [15:0] opA, opB;
    logic        test_mult_start;
    logic [4:0]  status_out;
    logic [7:0]  test_index;
    logic        done;

    always #5 clock = ~clock;

    mult_test_seq #(
        .NUM_TESTS      (N),
        .LFSR_SEED      (SEED),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .begin_test      (begin_test),
        .inject_error    (inject_error),
        .busy            (busy),
        .results_match   (results_match),
        .opA             (opA),
        .opB             (opB),
        .test_mult_start (test_mult_start),
        .status_out      (status_out),
        .test_index      (test_index),
        .done            (done)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    logic [31:0] ops_tab [N];

    // Environment configuration, written by the main process
    int          cfg_b    = 17;
    logic [7:0]  bad_idx  = 8'hFF;
    int          inj_mode = 0;
    int          inj_k    = 0;
    bit          dead_cfg = 1'b0;
    int          idle_req = 0;
    bit          mon_en   = 1'b0;
    int          exp_status, exp_idx, exp_starts;
    bit          exp_dead;

    // Environment state
    int          idle_ack   = 0;
    int          cur_b      = 0;
    int          busy_left  = 0;
    int          chk_left   = -1;
    bit          start_prev = 1'b0;

    // Monitor state
    int          m_phase = 0;
    int          m_starts, m_last_start;
    int          m_exp_status, m_exp_idx, m_exp_starts;
    bit          m_exp_dead;
    int          runs_checked = 0;

    // Gold multiplier agrees except on the designated bad test
    assign results_match = (test_index != bad_idx);

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Multiplier-under-test busy model and error injector
    initial begin
        busy = 1'b0;
        inject_error = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            inject_error = 1'b0;
            if (idle_req != idle_ack) begin
                inject_error = 1'b1;
                idle_ack = idle_req;
            end
            if (chk_left == 0) inject_error = 1'b1;
            if (chk_left >= 0) chk_left--;
            if (start_prev && !dead_cfg) begin
                cur_b = (cfg_b != 0) ? cfg_b : int'($urandom_range(1, 20));
                busy = 1'b1;
                busy_left = cur_b;
                if (inj_mode == 1 && int'(test_index) == inj_k) inject_error = 1'b1;
                if (inj_mode == 2 && int'(test_index) == inj_k) chk_left = cur_b;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) busy = 1'b0;
            end
            start_prev = test_mult_start;
        end
    end

    // Per-cycle compare against the run-level model
    always @(negedge clock) begin
        if (!mon_en) begin
            m_phase = 0;
        end else begin
            if (m_phase == 0) begin
                chk("idle_status", status_out, 5'h10);
                chk("idle_done", done, 1'b0);
            end else if (m_phase == 1) begin
                if (status_out == 5'h11) begin
                    chk("run_done", done, 1'b0);
                    if (test_mult_start) begin
                        if (m_starts >= N) begin
                            chk("extra_start", test_mult_start, 1'b0);
                        end else begin
                            chk("start_ops", {opA, opB}, ops_tab[m_starts]);
                            chk("start_index", test_index, m_starts);
                            if (m_starts > 0) chk("test_period", cyc - m_last_start, cur_b + 4);
                        end
                        m_last_start = cyc;
                        m_starts++;
                    end else if (m_starts > 0 && m_starts <= N) begin
                        chk("hold_ops", {opA, opB}, ops_tab[m_starts-1]);
                        chk("hold_index", test_index, m_starts - 1);
                    end
                end else begin
                    chk("final_status", status_out, m_exp_status);
                    chk("final_done", done, 1'b1);
                    chk("final_index", test_index, m_exp_idx);
                    chk("start_total", m_starts, m_exp_starts);
                    chk("final_latency", cyc - m_last_start, m_exp_dead ? T : cur_b + 3);
                    m_phase = 2;
                    runs_checked++;
                end
            end else begin
                chk("term_status", status_out, m_exp_status);
                chk("term_done", done, 1'b1);
            end
            if (begin_test && m_phase != 1) begin
                m_exp_status = exp_status;
                m_exp_idx    = exp_idx;
                m_exp_starts = exp_starts;
                m_exp_dead   = exp_dead;
                m_starts     = 0;
                m_last_start = cyc;
                m_phase      = 1;
            end
        end
    end

    // Configure the environment, derive the run outcome, pulse begin_test
    task automatic launch(input int bfix, input logic [7:0] bad, input int imode, input int ik,
                          input bit idle_inj, input bit dead);
        int f;
        @(posedge clock);
        #1;
        cfg_b = bfix;
        bad_idx = bad;
        inj_mode = imode;
        inj_k = ik;
        dead_cfg = dead;
        f = N;
        if (idle_inj) f = 0;
        if (int'(bad) < f) f = int'(bad);
        if (imode != 0 && ik < f) f = ik;
        exp_dead = dead;
        if (dead) begin
            exp_status = 5'h14; exp_idx = 0; exp_starts = 1;
        end else if (f < N) begin
            exp_status = 5'h13; exp_idx = f; exp_starts = f + 1;
        end else begin
            exp_status = 5'h12; exp_idx = N - 1; exp_starts = N;
        end
        if (idle_inj) begin
            idle_req++;
            @(posedge clock);
            #1;
        end
        begin_test = 1'b1;
        @(posedge clock);
        #1;
        begin_test = 1'b0;
    endtask

    task automatic wait_run();
        int target;
        target = runs_checked + 1;
        for (int i = 0; i < 2000; i++) begin
            if (runs_checked >= target) break;
            @(posedge clock);
        end
        chk("run_completes", runs_checked >= target, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        int starts_seen;
        reset_n = 1'b0;
        begin_test = 1'b0;

        ops_tab[0] = SEED;
        for (int i = 1; i < N; i++) begin
            ops_tab[i] = (ops_tab[i-1] >> 1) ^ (ops_tab[i-1][0] ? 32'h8020_0003 : 32'h0);
        end
        chk("model_op0", ops_tab[0], 32'h1234_5678);
        chk("model_op1", ops_tab[1], 32'h091A_2B3C);
        chk("model_op3", ops_tab[3], 32'h0246_8ACF);
        chk("model_op4", ops_tab[4], 32'h8103_4564);

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_opA", opA, 16'h0);
        chk("rst_opB", opB, 16'h0);
        chk("rst_start", test_mult_start, 1'b0);
        chk("rst_status", status_out, 5'h10);
        chk("rst_index", test_index, 8'h0);
        chk("rst_done", done, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mon_en = 1'b1;

        launch(17, 8'hFF, 0, 0, 1'b0, 1'b0);   // all 16 pass
        wait_run();
        launch(17, 8'd3, 0, 0, 1'b0, 1'b0);    // gold mismatch on test 3
        wait_run();
        launch(17, 8'hFF, 0, 0, 1'b1, 1'b0);   // injected in idle, fails test 0
        wait_run();
        launch(17, 8'hFF, 0, 0, 1'b0, 1'b0);   // rerun passes
        wait_run();
        launch(17, 8'hFF, 0, 0, 1'b0, 1'b1);   // busy never rises
        wait_run();
        launch(5, 8'hFF, 2, 5, 1'b0, 1'b0);    // injected in CHECK cycle of test 5
        wait_run();
        launch(0, 8'hFF, 1, 9, 1'b0, 1'b0);    // injected at start of test 9
        wait_run();

        // begin_test while waiting for busy to fall is ignored
        launch(17, 8'hFF, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (test_index == 8'd2 && busy) break;
        end
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        begin_test = 1'b1;
        @(posedge clock);
        #1;
        begin_test = 1'b0;
        @(negedge clock);
        chk("ignored_begin_index", test_index, 8'd2);
        chk("ignored_begin_ops", {opA, opB}, ops_tab[2]);
        chk("ignored_begin_status", status_out, 5'h11);
        wait_run();

        // Reset in WAIT_DONE aborts the run
        @(posedge clock);
        #1;
        mon_en = 1'b0;
        launch(17, 8'hFF, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (test_index == 8'd1 && busy) break;
        end
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_opA", opA, 16'h0);
        chk("midrst_opB", opB, 16'h0);
        chk("midrst_start", test_mult_start, 1'b0);
        chk("midrst_status", status_out, 5'h10);
        chk("midrst_index", test_index, 8'h0);
        chk("midrst_done", done, 1'b0);
        reset_n = 1'b1;
        starts_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (test_mult_start) starts_seen++;
        end
        chk("midrst_no_start", starts_seen, 0);
        chk("midrst_idle", status_out, 5'h10);

        // A pending injection is discarded by reset
        @(posedge clock);
        #1;
        idle_req++;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mon_en = 1'b1;
        launch(3, 8'hFF, 0, 0, 1'b0, 1'b0);
        wait_run();

        for (int r = 0; r < 16; r++) begin
            bit         dead;
            bit         idle;
            int         imode;
            int         ik;
            logic [7:0] bad;
            dead  = ($urandom_range(0, 7) == 0);
            bad   = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, N - 1));
            imode = dead ? 0 : int'($urandom_range(0, 2));
            ik    = int'($urandom_range(0, N - 1));
            idle  = !dead && ($urandom_range(0, 5) == 0);
            launch(0, bad, imode, ik, idle, dead);
            wait_run();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
